hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer.sv | 110 +++++++++++
 tb/tb_hazard_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, taken-branch flush and multi-cycle
// mult/div stall, with a saturating count of stalled cycles.
module hazard_sequencer #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic        id_use_rt_i,
    input  logic        ex_memread_i,
    input  logic [4:0]  ex_regdst_i,
    input  logic        ex_md_start_i,
    input  logic        ex_md_div_i,
    input  logic        branch_taken_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        idex_hold_o,
    output logic        exmem_bubble_o,
    output logic        md_busy_o,
    output logic        md_done_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

    assign load_use = ex_memread_i & (ex_regdst_i != 5'd0) &
                      ((ex_regdst_i == id_rs_i) | (id_use_rt_i & (ex_regdst_i == id_rt_i)));

    // Outputs are Mealy; everything is forced low while reset is held.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        idex_hold_o    = 1'b0;
        exmem_bubble_o = 1'b0;
        md_busy_o      = 1'b0;
        md_done_o      = 1'b0;

        if (!rst_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
        end else if (state_q == RUN) begin
            if (branch_taken_i) begin
                ifid_flush_o = 1'b1;
                idex_flush_o = 1'b1;
            end else if (ex_md_start_i) begin
                pc_write_o     = 1'b0;
                ifid_write_o   = 1'b0;
                idex_hold_o    = 1'b1;
                exmem_bubble_o = 1'b1;
                md_busy_o      = 1'b1;
                cnt_d          = ex_md_div_i ? DIV_CNT : MUL_CNT;
                state_d        = MD_WAIT;
            end else if (load_use) begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
            end
        end else begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_hold_o    = 1'b1;
            exmem_bubble_o = 1'b1;
            md_busy_o      = 1'b1;
            cnt_d          = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                md_done_o = 1'b1;
                state_d   = RUN;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (!pc_write_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_hazard_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  id_rs_i, id_rt_i, ex_regdst_i;
    logic        id_use_rt_i, ex_memread_i, ex_md_start_i, ex_md_div_i, branch_taken_i;
    logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o;
    logic        idex_hold_o, exmem_bubble_o, md_busy_o, md_done_o;
    logic [15:0] stall_cnt_o;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [15:0] exp_stall = 16'd0;

    always #5 clk_i = ~clk_i;

    hazard_sequencer #(.MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_use_rt_i(id_use_rt_i),
        .ex_memread_i(ex_memread_i), .ex_regdst_i(ex_regdst_i),
        .ex_md_start_i(ex_md_start_i), .ex_md_div_i(ex_md_div_i),
        .branch_taken_i(branch_taken_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
        .idex_hold_o(idex_hold_o), .exmem_bubble_o(exmem_bubble_o),
        .md_busy_o(md_busy_o), .md_done_o(md_done_o),
        .stall_cnt_o(stall_cnt_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs_i = 5'd0; id_rt_i = 5'd0; id_use_rt_i = 1'b0;
        ex_memread_i = 1'b0; ex_regdst_i = 5'd0;
        ex_md_start_i = 1'b0; ex_md_div_i = 1'b0; branch_taken_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b0;
        branch_taken_i = 1'b1; ex_md_start_i = 1'b1;
        step(); step();
        cmp_cnt++;
        if ({pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, idex_hold_o,
             exmem_bubble_o, md_busy_o, md_done_o} !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, idex_hold_o,
                      exmem_bubble_o, md_busy_o, md_done_o});
        end
        cmp_cnt++;
        if (stall_cnt_o !== 16'd0) begin
            err_cnt++;
            $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt_o);
        end
        clear_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        cmp_cnt++;
        if ({pc_write_o, ifid_write_o, idex_flush_o, md_busy_o} !== 4'b1100) begin
            err_cnt++;
            $display("FAIL run_defaults: got %b required 1100",
                     {pc_write_o, ifid_write_o, idex_flush_o, md_busy_o});
        end
        step();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        ex_memread_i = 1'b1; ex_regdst_i = 5'd5; id_rs_i = 5'd5;
        @(negedge clk_i);
        cmp_cnt++;
        if ({pc_write_o, ifid_write_o, idex_flush_o, ifid_flush_o} !== 4'b0010) begin
            err_cnt++;
            $display("FAIL load_use_stall: got %b required 0010",
                     {pc_write_o, ifid_write_o, idex_flush_o, ifid_flush_o});
        end
        step();
        clear_inputs();
        exp_stall = exp_stall + 16'd1;
        @(negedge clk_i);
        cmp_cnt++;
        if ({pc_write_o, idex_flush_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL load_use_one_cycle: got %b required 10", {pc_write_o, idex_flush_o});
        end
        cmp_cnt++;
        if (stall_cnt_o !== exp_stall) begin
            err_cnt++;
            $display("FAIL load_use_stall_cnt: got %0d required %0d", stall_cnt_o, exp_stall);
        end
        step();
        $display("test_load_use done");
    endtask

    task automatic test_no_false_stall();
        ex_memread_i = 1'b1; ex_regdst_i = 5'd0; id_rs_i = 5'd0;
        @(negedge clk_i);
        cmp_cnt++;
        if (pc_write_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL no_stall_r0: got %b required 1", pc_write_o);
        end
        step();
        ex_regdst_i = 5'd7; id_rs_i = 5'd3; id_rt_i = 5'd7; id_use_rt_i = 1'b0;
        @(negedge clk_i);
        cmp_cnt++;
        if (pc_write_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL no_stall_rt_unused: got %b required 1", pc_write_o);
        end
        step();
        cmp_cnt++;
        if (stall_cnt_o !== exp_stall) begin
            err_cnt++;
            $display("FAIL no_stall_cnt: got %0d required %0d", stall_cnt_o, exp_stall);
        end
        id_use_rt_i = 1'b1;
        @(negedge clk_i);
        cmp_cnt++;
        if ({pc_write_o, idex_flush_o} !== 2'b01) begin
            err_cnt++;
            $display("FAIL stall_rt_used: got %b required 01", {pc_write_o, idex_flush_o});
        end
        step();
        clear_inputs();
        exp_stall = exp_stall + 16'd1;
        $display("test_no_false_stall done");
    endtask

    task automatic test_md(input logic is_div, input int lat);
        ex_md_start_i = 1'b1; ex_md_div_i = is_div;
        for (int i = 1; i <= lat + 1; i++) begin
            @(negedge clk_i);
            cmp_cnt++;
            if (pc_write_o !== (i > lat)) begin
                err_cnt++;
                $display("FAIL md_pc_write cyc %0d: got %b required %b", i, pc_write_o, (i > lat));
            end
            cmp_cnt++;
            if (md_done_o !== (i == lat)) begin
                err_cnt++;
                $display("FAIL md_done cyc %0d: got %b required %b", i, md_done_o, (i == lat));
            end
            cmp_cnt++;
            if ({idex_hold_o, exmem_bubble_o, md_busy_o} !== {3{i <= lat}}) begin
                err_cnt++;
                $display("FAIL md_hold cyc %0d: got %b required %b", i,
                         {idex_hold_o, exmem_bubble_o, md_busy_o}, {3{i <= lat}});
            end
            step();
            if (i == 1) clear_inputs();
        end
        exp_stall = exp_stall + 16'(lat);
        cmp_cnt++;
        if (stall_cnt_o !== exp_stall) begin
            err_cnt++;
            $display("FAIL md_stall_cnt: got %0d required %0d", stall_cnt_o, exp_stall);
        end
        $display("test_md div=%0b lat=%0d done", is_div, lat);
    endtask

    task automatic test_simultaneous();
        branch_taken_i = 1'b1; ex_md_start_i = 1'b1;
        ex_memread_i = 1'b1; ex_regdst_i = 5'd9; id_rs_i = 5'd9;
        @(negedge clk_i);
        cmp_cnt++;
        if ({ifid_flush_o, idex_flush_o, pc_write_o, idex_hold_o, md_busy_o} !== 5'b11100) begin
            err_cnt++;
            $display("FAIL simul_branch_wins: got %b required 11100",
                     {ifid_flush_o, idex_flush_o, pc_write_o, idex_hold_o, md_busy_o});
        end
        step();
        clear_inputs();
        @(negedge clk_i);
        cmp_cnt++;
        if ({pc_write_o, md_busy_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL simul_stays_run: got %b required 10", {pc_write_o, md_busy_o});
        end
        cmp_cnt++;
        if (stall_cnt_o !== exp_stall) begin
            err_cnt++;
            $display("FAIL simul_stall_cnt: got %0d required %0d", stall_cnt_o, exp_stall);
        end
        step();
        ex_md_start_i = 1'b1;
        step();
        ex_md_start_i = 1'b1; branch_taken_i = 1'b1;
        @(negedge clk_i);
        cmp_cnt++;
        if ({ifid_flush_o, idex_flush_o, pc_write_o, md_busy_o} !== 4'b0001) begin
            err_cnt++;
            $display("FAIL mdwait_branch_ignored: got %b required 0001",
                     {ifid_flush_o, idex_flush_o, pc_write_o, md_busy_o});
        end
        step();
        clear_inputs();
        step(); step();
        exp_stall = exp_stall + 16'd4;
        @(negedge clk_i);
        cmp_cnt++;
        if ({pc_write_o, stall_cnt_o} !== {1'b1, exp_stall}) begin
            err_cnt++;
            $display("FAIL mdwait_branch_total: got pc=%b cnt=%0d required pc=1 cnt=%0d",
                     pc_write_o, stall_cnt_o, exp_stall);
        end
        step();
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid_op();
        ex_md_start_i = 1'b1; ex_md_div_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk_i);
            cmp_cnt++;
            if ({pc_write_o, md_done_o} !== 2'b00) begin
                err_cnt++;
                $display("FAIL midop_pre cyc %0d: got %b required 00", i, {pc_write_o, md_done_o});
            end
            step();
            if (i == 1) clear_inputs();
        end
        #1 rst_i = 1'b0;
        #1;
        cmp_cnt++;
        if ({pc_write_o, ifid_write_o, idex_hold_o, exmem_bubble_o, md_busy_o, md_done_o}
            !== 6'b000000) begin
            err_cnt++;
            $display("FAIL midop_reset_outputs: got %b required 000000",
                     {pc_write_o, ifid_write_o, idex_hold_o, exmem_bubble_o, md_busy_o, md_done_o});
        end
        cmp_cnt++;
        if (stall_cnt_o !== 16'd0) begin
            err_cnt++;
            $display("FAIL midop_reset_cnt: got %0d required 0", stall_cnt_o);
        end
        step(); step();
        rst_i = 1'b1;
        exp_stall = 16'd0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            cmp_cnt++;
            if ({pc_write_o, md_done_o, md_busy_o} !== 3'b100) begin
                err_cnt++;
                $display("FAIL midop_after cyc %0d: got %b required 100", i,
                         {pc_write_o, md_done_o, md_busy_o});
            end
            step();
        end
        cmp_cnt++;
        if (stall_cnt_o !== exp_stall) begin
            err_cnt++;
            $display("FAIL midop_after_cnt: got %0d required %0d", stall_cnt_o, exp_stall);
        end
        $display("test_reset_mid_op done");
    endtask

    task automatic test_saturation();
        ex_memread_i = 1'b1; ex_regdst_i = 5'd12; id_rs_i = 5'd12;
        repeat (65534) @(posedge clk_i);
        #1;
        cmp_cnt++;
        if (stall_cnt_o !== 16'hFFFE) begin
            err_cnt++;
            $display("FAIL sat_before: got %h required fffe", stall_cnt_o);
        end
        repeat (66) @(posedge clk_i);
        #1;
        cmp_cnt++;
        if (stall_cnt_o !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL sat_hold: got %h required ffff", stall_cnt_o);
        end
        clear_inputs();
        step();
        $display("test_saturation done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_md(1'b1, 32);
        test_md(1'b0, 4);
        test_simultaneous();
        test_reset_mid_op();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
